// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN matrix-vector step controller: FP constants,
// weight bank indices and the controller state encoding.
package rnn_pkg;

    localparam logic [31:0] FP_ONE    = 32'h3F800000;
    localparam int          N_WEIGHTS = 9;

    localparam logic [3:0] W_00 = 4'd0;
    localparam logic [3:0] W_01 = 4'd1;
    localparam logic [3:0] W_02 = 4'd2;
    localparam logic [3:0] W_10 = 4'd3;
    localparam logic [3:0] W_11 = 4'd4;
    localparam logic [3:0] W_12 = 4'd5;
    localparam logic [3:0] W_20 = 4'd6;
    localparam logic [3:0] W_21 = 4'd7;
    localparam logic [3:0] W_22 = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_MUT.sv
// Combinational 3x3 FP32 matrix times vector: sum_rowN = (M_N0*v_0 + M_N1*v_1) + M_N2*v_2.
// Round-to-nearest-even; subnormal inputs and results are flushed to signed zero.
module matrix_MUT (
    input  logic [31:0] M_00,
    input  logic [31:0] M_01,
    input  logic [31:0] M_02,
    input  logic [31:0] M_10,
    input  logic [31:0] M_11,
    input  logic [31:0] M_12,
    input  logic [31:0] M_20,
    input  logic [31:0] M_21,
    input  logic [31:0] M_22,
    input  logic [31:0] v_0,
    input  logic [31:0] v_1,
    input  logic [31:0] v_2,
    output logic [31:0] sum_row0,
    output logic [31:0] sum_row1,
    output logic [31:0] sum_row2
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0]        prod;
        logic [23:0]        mant;
        logic               g, st;
        logic signed [10:0] e;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        s      = a[31] ^ b[31];
        if (a_nan || b_nan) return QNAN;
        if (a_inf || b_inf) return (a_zero || b_zero) ? QNAN : {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        if (prod[47]) begin
            mant = prod[47:24];
            g    = prod[23];
            st   = |prod[22:0];
            e    = e + 11'sd1;
        end else begin
            mant = prod[46:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        if (g && (st || mant[0])) begin
            if (mant == 24'hFFFFFF) begin
                mant = 24'h800000;
                e    = e + 11'sd1;
            end else begin
                mant = mant + 24'd1;
            end
        end
        if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 11'sd0) return {s, 31'd0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0]        hi, lo;
        logic [7:0]         d;
        logic [26:0]        mb, ms, shifted;
        logic [27:0]        sum;
        logic [23:0]        mant;
        logic [4:0]         lz;
        logic               st, found;
        logic signed [10:0] e;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan) return QNAN;
        if (a_inf && b_inf) return (a[31] != b[31]) ? QNAN : a;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
        if (a_zero) return b;
        if (b_zero) return a;
        if (a[30:0] >= b[30:0]) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        // Mantissas carry three extra bits: guard, round and a sticky LSB.
        d  = hi[30:23] - lo[30:23];
        mb = {1'b1, hi[22:0], 3'b000};
        ms = {1'b1, lo[22:0], 3'b000};
        if (d > 8'd26) begin
            shifted = 27'd0;
            st      = 1'b1;
        end else begin
            shifted = ms >> d;
            st      = ((shifted << d) != ms);
        end
        shifted[0] = shifted[0] | st;
        e = $signed({3'b000, hi[30:23]});
        if (hi[31] == lo[31]) begin
            sum = {1'b0, mb} + {1'b0, shifted};
            if (sum[27]) begin
                sum = {1'b0, sum[27:1]} | {27'd0, sum[0]};
                e   = e + 11'sd1;
            end
        end else begin
            sum = {1'b0, mb} - {1'b0, shifted};
            if (sum == 28'd0) return 32'd0;
            lz    = 5'd0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found && sum[i]) begin
                    found = 1'b1;
                    lz    = 5'(26 - i);
                end
            end
            sum = sum << lz;
            e   = e - $signed({6'd0, lz});
        end
        mant = sum[26:3];
        if (sum[2] && (sum[1] || sum[0] || sum[3])) begin
            if (mant == 24'hFFFFFF) begin
                mant = 24'h800000;
                e    = e + 11'sd1;
            end else begin
                mant = mant + 24'd1;
            end
        end
        if (e >= 11'sd255) return {hi[31], 8'hFF, 23'd0};
        if (e <= 11'sd0) return {hi[31], 31'd0};
        return {hi[31], e[7:0], mant[22:0]};
    endfunction

    assign sum_row0 = fp_add(fp_add(fp_mul(M_00, v_0), fp_mul(M_01, v_1)), fp_mul(M_02, v_2));
    assign sum_row1 = fp_add(fp_add(fp_mul(M_10, v_0), fp_mul(M_11, v_1)), fp_mul(M_12, v_2));
    assign sum_row2 = fp_add(fp_add(fp_mul(M_20, v_0), fp_mul(M_21, v_1)), fp_mul(M_22, v_2));

endmodule

// File: rtl/matvec_step_ctrl.sv
// Sequencer around the combinational matrix_MUT: weight bank, operand launch,
// multicycle settle, optional h <= M*h iteration and a valid/ready result port.
module matvec_step_ctrl
    import rnn_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUT_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [7:0]        in_steps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_0,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic              busy
);

    localparam logic [3:0] CNT_LOAD = 4'(MUT_LAT - 1);

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic [7:0]        steps_left;
    logic [DATA_W-1:0] weight [N_WEIGHTS];
    logic [DATA_W-1:0] opnd_0, opnd_1, opnd_2;
    logic [DATA_W-1:0] sum_0, sum_1, sum_2;
    logic              accept, capture, again, wr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        again    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    capture = 1'b1;
                    if (steps_left > 8'd1) begin
                        again = 1'b1;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Weights only change between vectors so the settling operands never see a moving matrix.
    assign wr_ok = cfg_we && (state == IDLE) && (cfg_addr <= W_22);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            steps_left <= '0;
            cfg_err    <= 1'b0;
            opnd_0     <= '0;
            opnd_1     <= '0;
            opnd_2     <= '0;
            out_0      <= '0;
            out_1      <= '0;
            out_2      <= '0;
            for (int i = 0; i < N_WEIGHTS; i++) begin
                weight[i] <= '0;
            end
        end else begin
            cfg_err <= cfg_we && !wr_ok;
            if (wr_ok) begin
                weight[cfg_addr] <= cfg_data;
            end
            if (accept) begin
                opnd_0     <= in_0;
                opnd_1     <= in_1;
                opnd_2     <= in_2;
                steps_left <= (in_steps == 8'd0) ? 8'd1 : in_steps;
                cnt        <= CNT_LOAD;
            end else if (state == WAIT) begin
                if (capture && again) begin
                    opnd_0     <= sum_0;
                    opnd_1     <= sum_1;
                    opnd_2     <= sum_2;
                    steps_left <= steps_left - 8'd1;
                    cnt        <= CNT_LOAD;
                end else if (capture) begin
                    out_0 <= sum_0;
                    out_1 <= sum_1;
                    out_2 <= sum_2;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    matrix_MUT u_mut (
        .M_00     (weight[W_00]),
        .M_01     (weight[W_01]),
        .M_02     (weight[W_02]),
        .M_10     (weight[W_10]),
        .M_11     (weight[W_11]),
        .M_12     (weight[W_12]),
        .M_20     (weight[W_20]),
        .M_21     (weight[W_21]),
        .M_22     (weight[W_22]),
        .v_0      (opnd_0),
        .v_1      (opnd_1),
        .v_2      (opnd_2),
        .sum_row0 (sum_0),
        .sum_row1 (sum_1),
        .sum_row2 (sum_2)
    );

    // in_ready is gated by rst_n so nothing is offered while the block is held in reset.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
